// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with hazard detection and branch PC-source select.
// Optional EX operand forwarding selects are enabled by defining FORWARD_EN.
`timescale 1ns/1ps
module control_pipeline #(
    parameter int CONTROL_SIZE = 8,
    parameter int REG_ADDR_W   = 5,
    parameter int RA_REG       = 31
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [CONTROL_SIZE-1:0] id_control,
    input  logic [1:0]              id_branch_src,
    input  logic [1:0]              id_compare_code,
    input  logic [REG_ADDR_W-1:0]   id_rs,
    input  logic [REG_ADDR_W-1:0]   id_rt,
    input  logic [REG_ADDR_W-1:0]   id_rd,
    input  logic                    id_operands_equal,
    output logic [CONTROL_SIZE-1:0] ex_control,
    output logic [REG_ADDR_W-1:0]   ex_dest,
    output logic [4:0]              mem_control,
    output logic [REG_ADDR_W-1:0]   mem_dest,
    output logic [2:0]              wb_control,
    output logic [REG_ADDR_W-1:0]   wb_dest,
    output logic                    stall,
    output logic                    if_flush,
    output logic [1:0]              pc_src
`ifdef FORWARD_EN
    ,
    output logic [1:0]              forward_a,
    output logic [1:0]              forward_b
`endif
);

    localparam int REGWRITE_BIT = 2;
    localparam int MEMREAD_BIT  = 4;
    localparam int REGDEST_LO   = 5;

    localparam logic [1:0] CMP_NONE = 2'b00;
    localparam logic [1:0] CMP_BEQ  = 2'b01;
    localparam logic [1:0] CMP_BNE  = 2'b10;
    localparam logic [1:0] CMP_JUMP = 2'b11;
    localparam logic [1:0] SRC_REG  = 2'b10;

    // Stage registers: _p0 = ID/EX, _p1 = EX/MEM, _p2 = MEM/WB
    logic [CONTROL_SIZE-1:0] ctrl_p0;
    logic [REG_ADDR_W-1:0]   dest_p0;
    logic [4:0]              ctrl_p1;
    logic [REG_ADDR_W-1:0]   dest_p1;
    logic [2:0]              ctrl_p2;
    logic [REG_ADDR_W-1:0]   dest_p2;
`ifdef FORWARD_EN
    logic [REG_ADDR_W-1:0]   rs_p0;
    logic [REG_ADDR_W-1:0]   rt_p0;
`endif

    logic [REG_ADDR_W-1:0] id_dest;
    logic ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt;
    logic check_rt, branch_active, branch_taken;
    logic load_use, branch_hazard, data_hazard;

    // Register 0 is hard-wired, so a write to it never creates a dependence.
    function automatic logic stage_writes(input logic                  reg_write,
                                          input logic [REG_ADDR_W-1:0] dest,
                                          input logic [REG_ADDR_W-1:0] src);
        return reg_write && (dest == src) && (src != '0);
    endfunction

    function automatic logic [REG_ADDR_W-1:0] resolve_dest(input logic [1:0]            reg_dest,
                                                           input logic [REG_ADDR_W-1:0] rd,
                                                           input logic [REG_ADDR_W-1:0] rt);
        logic [REG_ADDR_W-1:0] dest;
        case (reg_dest)
            2'b00:   dest = rd;
            2'b01:   dest = rt;
            2'b10:   dest = REG_ADDR_W'(RA_REG);
            default: dest = '0;
        endcase
        return dest;
    endfunction

    assign id_dest = resolve_dest(id_control[REGDEST_LO+1:REGDEST_LO], id_rd, id_rt);

    assign ex_wr_rs  = stage_writes(ctrl_p0[REGWRITE_BIT], dest_p0, id_rs);
    assign ex_wr_rt  = stage_writes(ctrl_p0[REGWRITE_BIT], dest_p0, id_rt);
    assign mem_wr_rs = stage_writes(ctrl_p1[REGWRITE_BIT], dest_p1, id_rs);
    assign mem_wr_rt = stage_writes(ctrl_p1[REGWRITE_BIT], dest_p1, id_rt);

    // Register jumps only consume rs; conditional branches also compare rt.
    assign branch_active = (id_compare_code != CMP_NONE);
    assign check_rt      = ((id_compare_code == CMP_BEQ) || (id_compare_code == CMP_BNE))
                           && (id_branch_src != SRC_REG);

    assign load_use = ctrl_p0[MEMREAD_BIT] && (ex_wr_rs || ex_wr_rt);

    assign branch_hazard = branch_active &&
                           (ex_wr_rs || (check_rt && ex_wr_rt) ||
                            (ctrl_p1[MEMREAD_BIT] && (mem_wr_rs || (check_rt && mem_wr_rt))));

`ifdef FORWARD_EN
    assign data_hazard = 1'b0;
`else
    // Without forwarding, an ALU consumer waits until its producer has reached WB.
    assign data_hazard = !branch_active && (ex_wr_rs || ex_wr_rt || mem_wr_rs || mem_wr_rt);
`endif

    assign stall = load_use || branch_hazard || data_hazard;

    always_comb begin
        branch_taken = 1'b0;
        pc_src       = 2'b00;
        if_flush     = 1'b0;
        case (id_compare_code)
            CMP_BEQ:  branch_taken = id_operands_equal;
            CMP_BNE:  branch_taken = !id_operands_equal;
            CMP_JUMP: branch_taken = 1'b1;
            default:  branch_taken = 1'b0;
        endcase
        if (branch_taken && !stall) begin
            pc_src   = id_branch_src + 2'd1;
            if_flush = 1'b1;
        end
    end

`ifdef FORWARD_EN
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (stage_writes(ctrl_p1[REGWRITE_BIT], dest_p1, rs_p0) && !ctrl_p1[MEMREAD_BIT])
            forward_a = 2'b10;
        else if (stage_writes(ctrl_p2[REGWRITE_BIT], dest_p2, rs_p0))
            forward_a = 2'b01;
        if (stage_writes(ctrl_p1[REGWRITE_BIT], dest_p1, rt_p0) && !ctrl_p1[MEMREAD_BIT])
            forward_b = 2'b10;
        else if (stage_writes(ctrl_p2[REGWRITE_BIT], dest_p2, rt_p0))
            forward_b = 2'b01;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_p0 <= '0;
            dest_p0 <= '0;
            ctrl_p1 <= '0;
            dest_p1 <= '0;
            ctrl_p2 <= '0;
            dest_p2 <= '0;
`ifdef FORWARD_EN
            rs_p0   <= '0;
            rt_p0   <= '0;
`endif
        end else begin
            // ID -> EX: a stall replaces the instruction with a bubble
            if (stall) begin
                ctrl_p0 <= '0;
                dest_p0 <= '0;
`ifdef FORWARD_EN
                rs_p0   <= '0;
                rt_p0   <= '0;
`endif
            end else begin
                ctrl_p0 <= id_control;
                dest_p0 <= id_dest;
`ifdef FORWARD_EN
                rs_p0   <= id_rs;
                rt_p0   <= id_rt;
`endif
            end
            // EX -> MEM
            ctrl_p1 <= ctrl_p0[4:0];
            dest_p1 <= dest_p0;
            // MEM -> WB
            ctrl_p2 <= ctrl_p1[2:0];
            dest_p2 <= dest_p1;
        end
    end

    assign ex_control  = ctrl_p0;
    assign ex_dest     = dest_p0;
    assign mem_control = ctrl_p1;
    assign mem_dest    = dest_p1;
    assign wb_control  = ctrl_p2;
    assign wb_dest     = dest_p2;

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: random and directed ID traffic against an instruction-list model.
`timescale 1ns/1ps
module tb_control_pipeline;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] id_control = '0;
    logic [1:0] id_branch_src = '0;
    logic [1:0] id_compare_code = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_operands_equal = 1'b0;
    logic [7:0] ex_control;
    logic [4:0] ex_dest, mem_control, mem_dest, wb_dest;
    logic [2:0] wb_control;
    logic       stall, if_flush;
    logic [1:0] pc_src;
`ifdef FORWARD_EN
    logic [1:0] forward_a, forward_b;
`endif

    control_pipeline dut (
        .clock(clock), .reset(reset),
        .id_control(id_control), .id_branch_src(id_branch_src),
        .id_compare_code(id_compare_code),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_operands_equal(id_operands_equal),
        .ex_control(ex_control), .ex_dest(ex_dest),
        .mem_control(mem_control), .mem_dest(mem_dest),
        .wb_control(wb_control), .wb_dest(wb_dest),
        .stall(stall), .if_flush(if_flush), .pc_src(pc_src)
`ifdef FORWARD_EN
        , .forward_a(forward_a), .forward_b(forward_b)
`endif
    );

    always #5 clock = ~clock;

    // One in-flight instruction; the model keeps the EX, MEM and WB occupants as a short list.
    typedef struct packed {
        logic [7:0] ctrl;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
    } instr_t;

    typedef struct {
        logic [7:0] ex_control;
        logic [4:0] ex_dest;
        logic [4:0] mem_control;
        logic [4:0] mem_dest;
        logic [2:0] wb_control;
        logic [4:0] wb_dest;
        logic       stall;
        logic       if_flush;
        logic [1:0] pc_src;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    instr_t pipe [3];
    exp_t   sb [$];
    int     tests = 0;
    int     failed = 0;
    logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd2, 5'd31};

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic writes(input instr_t s, input logic [4:0] r);
        return s.ctrl[2] && (s.dest == r) && (r != 5'd0);
    endfunction

    function automatic logic [4:0] resolve(input logic [7:0] c, input logic [4:0] rd, input logic [4:0] rt);
        case (c[6:5])
            2'b00:   return rd;
            2'b01:   return rt;
            2'b10:   return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
        if (writes(pipe[1], r) && !pipe[1].ctrl[4]) return 2'b10;
        if (writes(pipe[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic st = 1'b0;
        logic taken;
        logic [4:0] ops [$];
        e.ex_control  = pipe[0].ctrl;
        e.ex_dest     = pipe[0].dest;
        e.mem_control = pipe[1].ctrl[4:0];
        e.mem_dest    = pipe[1].dest;
        e.wb_control  = pipe[2].ctrl[2:0];
        e.wb_dest     = pipe[2].dest;
        if (pipe[0].ctrl[4] && (writes(pipe[0], id_rs) || writes(pipe[0], id_rt))) st = 1'b1;
        if (id_compare_code != 2'b00) begin
            ops.push_back(id_rs);
            if (id_compare_code != 2'b11 && id_branch_src != 2'b10) ops.push_back(id_rt);
            foreach (ops[k]) begin
                if (writes(pipe[0], ops[k])) st = 1'b1;
                if (pipe[1].ctrl[4] && writes(pipe[1], ops[k])) st = 1'b1;
            end
        end
`ifndef FORWARD_EN
        else begin
            for (int s = 0; s < 2; s++)
                if (writes(pipe[s], id_rs) || writes(pipe[s], id_rt)) st = 1'b1;
        end
`endif
        taken = (id_compare_code == 2'b11) ||
                (id_compare_code == 2'b01 && id_operands_equal) ||
                (id_compare_code == 2'b10 && !id_operands_equal);
        e.stall    = st;
        e.if_flush = taken && !st;
        e.pc_src   = (taken && !st) ? id_branch_src + 2'd1 : 2'b00;
        e.fa       = fwd_sel(pipe[0].rs);
        e.fb       = fwd_sel(pipe[0].rt);
        return e;
    endfunction

    task automatic model_edge();
        logic st;
        st = predict().stall;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (st) pipe[0] = '0;
        else    pipe[0] = '{id_control, resolve(id_control, id_rd, id_rt), id_rs, id_rt};
    endtask

    task automatic step(input logic [7:0] c, input logic [1:0] bs, input logic [1:0] cc,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic eq);
        @(posedge clock);
        #1;
        model_edge();
        id_control = c; id_branch_src = bs; id_compare_code = cc;
        id_rs = rs; id_rt = rt; id_rd = rd; id_operands_equal = eq;
        sb.push_back(predict());
    endtask

    task automatic nop();
        step(8'h00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_ex_control"}, 32'(ex_control), 32'h0);
        cmp({tag, "_ex_dest"}, 32'(ex_dest), 32'h0);
        cmp({tag, "_mem_control"}, 32'(mem_control), 32'h0);
        cmp({tag, "_mem_dest"}, 32'(mem_dest), 32'h0);
        cmp({tag, "_wb_control"}, 32'(wb_control), 32'h0);
        cmp({tag, "_wb_dest"}, 32'(wb_dest), 32'h0);
        cmp({tag, "_stall"}, 32'(stall), 32'h0);
    endtask

    // Assert reset between edges, check the asynchronous clear, then release on a falling edge.
    task automatic mid_cycle_reset(input string tag);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero(tag);
        id_control = '0; id_branch_src = '0; id_compare_code = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_operands_equal = 1'b0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("ex_control", 32'(ex_control), 32'(e.ex_control));
                cmp("ex_dest", 32'(ex_dest), 32'(e.ex_dest));
                cmp("mem_control", 32'(mem_control), 32'(e.mem_control));
                cmp("mem_dest", 32'(mem_dest), 32'(e.mem_dest));
                cmp("wb_control", 32'(wb_control), 32'(e.wb_control));
                cmp("wb_dest", 32'(wb_dest), 32'(e.wb_dest));
                cmp("stall", 32'(stall), 32'(e.stall));
                cmp("if_flush", 32'(if_flush), 32'(e.if_flush));
                cmp("pc_src", 32'(pc_src), 32'(e.pc_src));
`ifdef FORWARD_EN
                cmp("forward_a", 32'(forward_a), 32'(e.fa));
                cmp("forward_b", 32'(forward_b), 32'(e.fb));
`endif
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        #12;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 1500; i++)
            step(8'($urandom), 2'($urandom_range(0, 2)), 2'($urandom),
                 regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
                 regs[$urandom_range(0, 3)], 1'($urandom));

        // Load-use: lw r8 followed by a reader of r8.
        repeat (3) nop();
        step(8'hB5, 2'b00, 2'b00, 5'd0, 5'd8, 5'd0, 1'b0);
        step(8'h04, 2'b00, 2'b00, 5'd8, 5'd0, 5'd9, 1'b0);
        #1;
        cmp("lu_stall", 32'(stall), 32'h1);
        cmp("lu_ex_is_lw", 32'(ex_control), 32'hB5);
        step(8'h04, 2'b00, 2'b00, 5'd8, 5'd0, 5'd9, 1'b0);
        #1;
        cmp("lu_bubble", 32'(ex_control), 32'h0);
        cmp("lu_mem_dest", 32'(mem_dest), 32'd8);
`ifdef FORWARD_EN
        cmp("lu_stall_released", 32'(stall), 32'h0);
`else
        cmp("lu_stall_mem_raw", 32'(stall), 32'h1);
`endif

        // beq taken and not taken with a drained pipeline.
        repeat (3) nop();
        step(8'h00, 2'b00, 2'b01, 5'd1, 5'd2, 5'd0, 1'b1);
        #1;
        cmp("beq_taken_pc", 32'(pc_src), 32'h1);
        cmp("beq_taken_flush", 32'(if_flush), 32'h1);
        step(8'h00, 2'b00, 2'b01, 5'd1, 5'd2, 5'd0, 1'b0);
        #1;
        cmp("beq_nt_pc", 32'(pc_src), 32'h0);
        cmp("beq_nt_flush", 32'(if_flush), 32'h0);

        // jal: jump target, link register 31 reaches WB three edges later.
        step(8'h46, 2'b01, 2'b11, 5'd0, 5'd0, 5'd7, 1'b0);
        #1;
        cmp("jal_pc", 32'(pc_src), 32'h2);
        cmp("jal_flush", 32'(if_flush), 32'h1);
        repeat (3) nop();
        #1;
        cmp("jal_wb_dest", 32'(wb_dest), 32'd31);
        cmp("jal_wb_control", 32'(wb_control), 32'h6);

        // jr r31 waits for an ALU writer of r31 to leave EX.
        repeat (3) nop();
        step(8'h04, 2'b00, 2'b00, 5'd0, 5'd0, 5'd31, 1'b0);
        step(8'h00, 2'b10, 2'b11, 5'd31, 5'd0, 5'd0, 1'b0);
        #1;
        cmp("jr_stall", 32'(stall), 32'h1);
        cmp("jr_stall_pc", 32'(pc_src), 32'h0);
        step(8'h00, 2'b10, 2'b11, 5'd31, 5'd0, 5'd0, 1'b0);
        #1;
        cmp("jr_go_stall", 32'(stall), 32'h0);
        cmp("jr_go_pc", 32'(pc_src), 32'h3);

        // Asynchronous reset with an all-ones bundle in EX.
        repeat (3) nop();
        step(8'hFF, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        nop();
        #1;
        cmp("pre_reset_ex", 32'(ex_control), 32'hFF);
        mid_cycle_reset("rst_ff");

        // Reset while a load-use stall is active.
        step(8'hB5, 2'b00, 2'b00, 5'd0, 5'd8, 5'd0, 1'b0);
        step(8'h04, 2'b00, 2'b00, 5'd8, 5'd0, 5'd9, 1'b0);
        #1;
        cmp("pre_reset_stall", 32'(stall), 32'h1);
        mid_cycle_reset("rst_stall");

`ifdef FORWARD_EN
        step(8'h04, 2'b00, 2'b00, 5'd0, 5'd0, 5'd5, 1'b0);
        step(8'h04, 2'b00, 2'b00, 5'd0, 5'd0, 5'd5, 1'b0);
        step(8'h04, 2'b00, 2'b00, 5'd5, 5'd0, 5'd6, 1'b0);
        nop();
        #1;
        cmp("fwd_mem", 32'(forward_a), 32'h2);
        step(8'h04, 2'b00, 2'b00, 5'd0, 5'd0, 5'd5, 1'b0);
        step(8'h04, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        step(8'h04, 2'b00, 2'b00, 5'd5, 5'd0, 5'd6, 1'b0);
        nop();
        #1;
        cmp("fwd_wb", 32'(forward_a), 32'h1);
`endif

        repeat (2) @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
